// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: RO/EX latch occupancy encoding and destination width.
package cpu_pipe_pkg;

  localparam int unsigned REG_W = 3;

  typedef enum logic [1:0] {
    LATCH_EMPTY = 2'b00,
    LATCH_LIVE  = 2'b01,
    LATCH_HELD  = 2'b10
  } latch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic at_max;
  assign at_max = (cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ro_ex_latch.sv
// RO->EX pipeline register: loads on ld_ex, holds while EX stalls, drops the entry on flush.
// Registered destination enables feed the RO dependency-stall compare.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   LATCH_EMPTY | no valid instruction in EX (bubble or flushed)
//   LATCH_LIVE  | valid instruction, loaded on the last edge
//   LATCH_HELD  | valid instruction, held by an EX stall
module ro_ex_latch
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MM_W    = 64,
  parameter int unsigned ALUOP_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_ex,
  input  logic               V_ex,
  input  logic               flush,
  input  logic               perf_clr,
  input  logic [DATA_W-1:0]  ro_eip,
  input  logic [DATA_W-1:0]  ro_op1,
  input  logic [DATA_W-1:0]  ro_op2,
  input  logic [MM_W-1:0]    ro_mm1,
  input  logic [MM_W-1:0]    ro_mm2,
  input  logic [ALUOP_W-1:0] ro_aluop,
  input  logic [REG_W-1:0]   ro_dreg1,
  input  logic [REG_W-1:0]   ro_dreg2,
  input  logic [REG_W-1:0]   ro_dreg3,
  input  logic               v_ro_ld_reg1,
  input  logic               v_ro_ld_reg2,
  input  logic               v_ro_ld_reg3,
  input  logic [REG_W-1:0]   ro_dmm,
  input  logic               v_ro_ld_mm,
  input  logic [REG_W-1:0]   ro_dseg,
  input  logic               v_ro_ld_seg,
  input  logic               v_ro_ld_flag_ZF,
  output logic [DATA_W-1:0]  ex_eip,
  output logic [DATA_W-1:0]  ex_op1,
  output logic [DATA_W-1:0]  ex_op2,
  output logic [MM_W-1:0]    ex_mm1,
  output logic [MM_W-1:0]    ex_mm2,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [REG_W-1:0]   ex_dreg1,
  output logic [REG_W-1:0]   ex_dreg2,
  output logic [REG_W-1:0]   ex_dreg3,
  output logic [REG_W-1:0]   ex_dmm,
  output logic [REG_W-1:0]   ex_dseg,
  output logic               v_ex_ld_reg1,
  output logic               v_ex_ld_reg2,
  output logic               v_ex_ld_reg3,
  output logic               v_ex_ld_mm,
  output logic               v_ex_ld_seg,
  output logic               v_ex_ld_flag_ZF,
  output logic               V_ex_q,
  output logic               ex_held,
  output logic [CNT_W-1:0]   hold_cnt
);

  latch_state_t state_q;
  latch_state_t state_d;
  logic         load_en;

  assign load_en = ld_ex & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LATCH_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = LATCH_EMPTY;
    end else if (ld_ex) begin
      state_d = V_ex ? LATCH_LIVE : LATCH_EMPTY;
    end else begin
      case (state_q)
        LATCH_EMPTY: state_d = LATCH_EMPTY;
        LATCH_LIVE:  state_d = LATCH_HELD;
        LATCH_HELD:  state_d = LATCH_HELD;
        default:     state_d = LATCH_EMPTY;
      endcase
    end
  end

  assign V_ex_q  = (state_q != LATCH_EMPTY);
  assign ex_held = (state_q == LATCH_HELD);

  // Payload is functionally don't-care when empty; reset only keeps it X-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_eip   <= '0;
      ex_op1   <= '0;
      ex_op2   <= '0;
      ex_mm1   <= '0;
      ex_mm2   <= '0;
      ex_aluop <= '0;
      ex_dreg1 <= '0;
      ex_dreg2 <= '0;
      ex_dreg3 <= '0;
      ex_dmm   <= '0;
      ex_dseg  <= '0;
    end else if (load_en) begin
      ex_eip   <= ro_eip;
      ex_op1   <= ro_op1;
      ex_op2   <= ro_op2;
      ex_mm1   <= ro_mm1;
      ex_mm2   <= ro_mm2;
      ex_aluop <= ro_aluop;
      ex_dreg1 <= ro_dreg1;
      ex_dreg2 <= ro_dreg2;
      ex_dreg3 <= ro_dreg3;
      ex_dmm   <= ro_dmm;
      ex_dseg  <= ro_dseg;
    end
  end

  // Enables are qualified by valid before the flop so a bubble never advertises a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_ex_ld_reg1    <= 1'b0;
      v_ex_ld_reg2    <= 1'b0;
      v_ex_ld_reg3    <= 1'b0;
      v_ex_ld_mm      <= 1'b0;
      v_ex_ld_seg     <= 1'b0;
      v_ex_ld_flag_ZF <= 1'b0;
    end else if (flush) begin
      v_ex_ld_reg1    <= 1'b0;
      v_ex_ld_reg2    <= 1'b0;
      v_ex_ld_reg3    <= 1'b0;
      v_ex_ld_mm      <= 1'b0;
      v_ex_ld_seg     <= 1'b0;
      v_ex_ld_flag_ZF <= 1'b0;
    end else if (ld_ex) begin
      v_ex_ld_reg1    <= v_ro_ld_reg1 & V_ex;
      v_ex_ld_reg2    <= v_ro_ld_reg2 & V_ex;
      v_ex_ld_reg3    <= v_ro_ld_reg3 & V_ex;
      v_ex_ld_mm      <= v_ro_ld_mm & V_ex;
      v_ex_ld_seg     <= v_ro_ld_seg & V_ex;
      v_ex_ld_flag_ZF <= v_ro_ld_flag_ZF & V_ex;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state_d == LATCH_HELD),
    .clr   (perf_clr),
    .cnt   (hold_cnt)
  );

endmodule

// File: tb/tb_ro_ex_latch.sv
// Scoreboard bench for ro_ex_latch: a default-width instance and a CNT_W=2 instance share stimulus.
module tb_ro_ex_latch;

  typedef struct packed {
    logic [31:0] eip;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [63:0] mm1;
    logic [63:0] mm2;
    logic [4:0]  aluop;
    logic [2:0]  d1;
    logic [2:0]  d2;
    logic [2:0]  d3;
    logic [2:0]  dmm;
    logic [2:0]  dseg;
  } data_t;

  // en order: {reg1, reg2, reg3, mm, seg, ZF}
  typedef struct packed {
    logic        v;
    logic        held;
    logic [5:0]  en;
    logic [15:0] cnt;
    logic [1:0]  scnt;
  } ctrl_t;

  typedef struct {
    string nm;
    ctrl_t c;
    bit    cd;
    data_t d;
  } exp_t;

  localparam data_t D_Z = '0;
  localparam data_t D_A = '{eip: 32'h0000_1000, op1: 32'hDEAD_BEEF, op2: 32'h1234_5678,
                            mm1: 64'h0123_4567_89AB_CDEF, mm2: 64'hFEDC_BA98_7654_3210,
                            aluop: 5'h0A, d1: 3'h2, d2: 3'h5, d3: 3'h7, dmm: 3'h3, dseg: 3'h4};
  localparam data_t D_B = '{eip: 32'h0000_2000, op1: 32'hCAFE_F00D, op2: 32'h8765_4321,
                            mm1: 64'h1111_2222_3333_4444, mm2: 64'h5555_6666_7777_8888,
                            aluop: 5'h15, d1: 3'h6, d2: 3'h1, d3: 3'h3, dmm: 3'h5, dseg: 3'h2};
  localparam data_t D_C = '{eip: 32'h0000_3000, op1: 32'h0BAD_C0DE, op2: 32'hFFFF_0000,
                            mm1: 64'hAAAA_5555_AAAA_5555, mm2: 64'h0F0F_0F0F_F0F0_F0F0,
                            aluop: 5'h1F, d1: 3'h1, d2: 3'h4, d3: 3'h6, dmm: 3'h7, dseg: 3'h1};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ld_ex = 1'b0;
  logic V_ex = 1'b0;
  logic flush = 1'b0;
  logic perf_clr = 1'b0;
  data_t in_d = '0;
  logic [5:0] in_en = '0;

  logic [31:0] ex_eip, ex_op1, ex_op2;
  logic [63:0] ex_mm1, ex_mm2;
  logic [4:0]  ex_aluop;
  logic [2:0]  ex_dreg1, ex_dreg2, ex_dreg3, ex_dmm, ex_dseg;
  logic v_ex_ld_reg1, v_ex_ld_reg2, v_ex_ld_reg3, v_ex_ld_mm, v_ex_ld_seg, v_ex_ld_flag_ZF;
  logic V_ex_q, ex_held;
  logic [15:0] hold_cnt;

  logic [31:0] s_eip, s_op1, s_op2;
  logic [63:0] s_mm1, s_mm2;
  logic [4:0]  s_aluop;
  logic [2:0]  s_dreg1, s_dreg2, s_dreg3, s_dmm, s_dseg;
  logic s_ld_reg1, s_ld_reg2, s_ld_reg3, s_ld_mm, s_ld_seg, s_ld_zf;
  logic s_v, s_held;
  logic [1:0] s_hold_cnt;

  always #5 clk = ~clk;

  ro_ex_latch dut (
    .clk(clk), .rst_n(rst_n), .ld_ex(ld_ex), .V_ex(V_ex), .flush(flush), .perf_clr(perf_clr),
    .ro_eip(in_d.eip), .ro_op1(in_d.op1), .ro_op2(in_d.op2),
    .ro_mm1(in_d.mm1), .ro_mm2(in_d.mm2), .ro_aluop(in_d.aluop),
    .ro_dreg1(in_d.d1), .ro_dreg2(in_d.d2), .ro_dreg3(in_d.d3),
    .v_ro_ld_reg1(in_en[5]), .v_ro_ld_reg2(in_en[4]), .v_ro_ld_reg3(in_en[3]),
    .ro_dmm(in_d.dmm), .v_ro_ld_mm(in_en[2]), .ro_dseg(in_d.dseg), .v_ro_ld_seg(in_en[1]),
    .v_ro_ld_flag_ZF(in_en[0]),
    .ex_eip(ex_eip), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_mm1(ex_mm1), .ex_mm2(ex_mm2),
    .ex_aluop(ex_aluop), .ex_dreg1(ex_dreg1), .ex_dreg2(ex_dreg2), .ex_dreg3(ex_dreg3),
    .ex_dmm(ex_dmm), .ex_dseg(ex_dseg),
    .v_ex_ld_reg1(v_ex_ld_reg1), .v_ex_ld_reg2(v_ex_ld_reg2), .v_ex_ld_reg3(v_ex_ld_reg3),
    .v_ex_ld_mm(v_ex_ld_mm), .v_ex_ld_seg(v_ex_ld_seg), .v_ex_ld_flag_ZF(v_ex_ld_flag_ZF),
    .V_ex_q(V_ex_q), .ex_held(ex_held), .hold_cnt(hold_cnt)
  );

  ro_ex_latch #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .ld_ex(ld_ex), .V_ex(V_ex), .flush(flush), .perf_clr(perf_clr),
    .ro_eip(in_d.eip), .ro_op1(in_d.op1), .ro_op2(in_d.op2),
    .ro_mm1(in_d.mm1), .ro_mm2(in_d.mm2), .ro_aluop(in_d.aluop),
    .ro_dreg1(in_d.d1), .ro_dreg2(in_d.d2), .ro_dreg3(in_d.d3),
    .v_ro_ld_reg1(in_en[5]), .v_ro_ld_reg2(in_en[4]), .v_ro_ld_reg3(in_en[3]),
    .ro_dmm(in_d.dmm), .v_ro_ld_mm(in_en[2]), .ro_dseg(in_d.dseg), .v_ro_ld_seg(in_en[1]),
    .v_ro_ld_flag_ZF(in_en[0]),
    .ex_eip(s_eip), .ex_op1(s_op1), .ex_op2(s_op2), .ex_mm1(s_mm1), .ex_mm2(s_mm2),
    .ex_aluop(s_aluop), .ex_dreg1(s_dreg1), .ex_dreg2(s_dreg2), .ex_dreg3(s_dreg3),
    .ex_dmm(s_dmm), .ex_dseg(s_dseg),
    .v_ex_ld_reg1(s_ld_reg1), .v_ex_ld_reg2(s_ld_reg2), .v_ex_ld_reg3(s_ld_reg3),
    .v_ex_ld_mm(s_ld_mm), .v_ex_ld_seg(s_ld_seg), .v_ex_ld_flag_ZF(s_ld_zf),
    .V_ex_q(s_v), .ex_held(s_held), .hold_cnt(s_hold_cnt)
  );

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  function automatic ctrl_t mkc(logic v, logic held, logic [5:0] en, int cnt, int scnt);
    ctrl_t c;
    c.v    = v;
    c.held = held;
    c.en   = en;
    c.cnt  = 16'(cnt);
    c.scnt = 2'(scnt);
    return c;
  endfunction

  function automatic void push(string nm, ctrl_t c, bit cd, data_t d);
    exp_t e;
    e.nm = nm;
    e.c  = c;
    e.cd = cd;
    e.d  = d;
    sb_q.push_back(e);
  endfunction

  // Drive one cycle's inputs at the falling edge and queue what must show after the rising edge.
  task automatic step(input string nm, input logic ld, input logic v, input logic fl,
                      input logic clr, input data_t d, input logic [5:0] en,
                      input ctrl_t ec, input bit cd, input data_t ed);
    @(negedge clk);
    ld_ex    = ld;
    V_ex     = v;
    flush    = fl;
    perf_clr = clr;
    in_d     = d;
    in_en    = en;
    push(nm, ec, cd, ed);
  endtask

  // Monitor: outputs settle after every rising edge and after an async reset assertion.
  initial begin
    exp_t  e;
    ctrl_t ac;
    data_t ad;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        ac.v    = V_ex_q;
        ac.held = ex_held;
        ac.en   = {v_ex_ld_reg1, v_ex_ld_reg2, v_ex_ld_reg3, v_ex_ld_mm, v_ex_ld_seg, v_ex_ld_flag_ZF};
        ac.cnt  = hold_cnt;
        ac.scnt = s_hold_cnt;
        total++;
        if (ac !== e.c) begin
          bad++;
          $display("FAIL %s ctrl: got v=%b held=%b en=%b cnt=%0d scnt=%0d want v=%b held=%b en=%b cnt=%0d scnt=%0d",
                   e.nm, ac.v, ac.held, ac.en, ac.cnt, ac.scnt,
                   e.c.v, e.c.held, e.c.en, e.c.cnt, e.c.scnt);
        end
        if (e.cd) begin
          ad = '{eip: ex_eip, op1: ex_op1, op2: ex_op2, mm1: ex_mm1, mm2: ex_mm2,
                 aluop: ex_aluop, d1: ex_dreg1, d2: ex_dreg2, d3: ex_dreg3,
                 dmm: ex_dmm, dseg: ex_dseg};
          total++;
          if (ad !== e.d) begin
            bad++;
            $display("FAIL %s data: got %h want %h", e.nm, ad, e.d);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    push("reset", mkc(0, 0, 6'b000000, 0, 0), 1, D_Z);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step("load_a", 1, 1, 0, 0, D_A, 6'b100000, mkc(1, 0, 6'b100000, 0, 0), 1, D_A);
    for (int i = 1; i <= 3; i++)
      step($sformatf("hold_a_%0d", i), 0, 1, 0, 0, D_B, 6'b111111,
           mkc(1, 1, 6'b100000, i, i), 1, D_A);
    step("bubble", 1, 0, 0, 0, D_C, 6'b010100, mkc(0, 0, 6'b000000, 3, 3), 1, D_C);
    step("load_b_en", 1, 1, 0, 0, D_B, 6'b011111, mkc(1, 0, 6'b011111, 3, 3), 1, D_B);
    step("hold_b", 0, 0, 0, 0, D_A, 6'b000000, mkc(1, 1, 6'b011111, 4, 3), 1, D_B);
    step("flush_held", 0, 0, 1, 0, D_A, 6'b000000, mkc(0, 0, 6'b000000, 4, 3), 0, D_Z);
    step("load_a_all", 1, 1, 0, 0, D_A, 6'b111111, mkc(1, 0, 6'b111111, 4, 3), 1, D_A);
    step("hold_a_all", 0, 1, 0, 0, D_C, 6'b111111, mkc(1, 1, 6'b111111, 5, 3), 1, D_A);
    step("flush_vs_load", 1, 1, 1, 0, D_C, 6'b111111, mkc(0, 0, 6'b000000, 5, 3), 0, D_Z);
    step("empty_idle", 0, 1, 0, 0, D_C, 6'b111111, mkc(0, 0, 6'b000000, 5, 3), 0, D_Z);
    step("clr_empty", 0, 0, 0, 1, D_C, 6'b000000, mkc(0, 0, 6'b000000, 0, 0), 0, D_Z);
    step("load_c", 1, 1, 0, 0, D_C, 6'b000001, mkc(1, 0, 6'b000001, 0, 0), 1, D_C);
    for (int i = 1; i <= 5; i++)
      step($sformatf("sat_hold_%0d", i), 0, 1, 0, 0, D_B, 6'b111111,
           mkc(1, 1, 6'b000001, i, (i > 3) ? 3 : i), 1, D_C);
    step("clr_held", 0, 0, 0, 1, D_B, 6'b000000, mkc(1, 1, 6'b000001, 0, 0), 1, D_C);
    step("hold_after_clr", 0, 0, 0, 0, D_B, 6'b000000, mkc(1, 1, 6'b000001, 1, 1), 1, D_C);
    step("load_b_live", 1, 1, 0, 0, D_B, 6'b111000, mkc(1, 0, 6'b111000, 1, 1), 1, D_B);

    @(negedge clk);
    ld_ex = 1'b0;
    V_ex  = 1'b0;
    push("async_rst", mkc(0, 0, 6'b000000, 0, 0), 1, D_Z);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    step("post_rst_idle", 0, 0, 0, 0, D_A, 6'b111111, mkc(0, 0, 6'b000000, 0, 0), 1, D_Z);
    step("load_after_rst", 1, 1, 0, 0, D_A, 6'b000010, mkc(1, 0, 6'b000010, 0, 0), 1, D_A);

    repeat (3) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
